// File: rtl/fm_bus_arbiter.sv
// fm_bus_arbiter
//   Two-requester round-robin arbiter and bus sequencer for the FM core's
//   register port. Requester 0 is the host and requester 1 is the playback
//   sequencer. Each granted access runs SETUP, then STROBE (write) or RDWAIT
//   (read), then RECOVER. The arbiter then returns to IDLE and arbitrates
//   again.
// Ports:
//   clk, rst             - system clock, synchronous active-high reset
//   rN_valid/rN_ready    - request handshake (ready is combinational)
//   rN_rwn/addr/wdata    - request fields (1 = read)
//   rN_rdata/rN_rvalid   - read data and its one-cycle strobe
//   fm_addr/fm_dout      - registered FM core address and write data
//   fm_oe                - drive fm_dout onto the data bus
//   fm_rwn               - FM core RWn; 0 = write strobe
//   fm_din               - FM core read data
module fm_bus_arbiter #(
    parameter int STROBE_CYC = 2,
    parameter int READ_CYC   = 2,
    parameter int GAP_CYC    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       r0_valid,
    output logic       r0_ready,
    input  logic       r0_rwn,
    input  logic [5:0] r0_addr,
    input  logic [7:0] r0_wdata,
    output logic [7:0] r0_rdata,
    output logic       r0_rvalid,
    input  logic       r1_valid,
    output logic       r1_ready,
    input  logic       r1_rwn,
    input  logic [5:0] r1_addr,
    input  logic [7:0] r1_wdata,
    output logic [7:0] r1_rdata,
    output logic       r1_rvalid,
    output logic [5:0] fm_addr,
    output logic [7:0] fm_dout,
    output logic       fm_oe,
    output logic       fm_rwn,
    input  logic [7:0] fm_din
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_RDWAIT  = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

    // Counter load values: each timed state lasts load+1 cycles.
    localparam logic [7:0] STROBE_LOAD = 8'(STROBE_CYC - 1);
    localparam logic [7:0] READ_LOAD   = 8'(READ_CYC - 1);
    localparam logic [7:0] GAP_LOAD    = 8'(GAP_CYC - 1);

    state_t      state_r;
    state_t      state_next_s;
    logic [7:0]  cnt_r;
    logic [7:0]  cnt_next_s;
    logic        rr_r;
    logic        lat_rwn_r;
    logic        lat_id_r;
    logic        grant_s;
    logic        accept_s;
    logic        req_rwn_s;
    logic [5:0]  req_addr_s;
    logic [7:0]  req_wdata_s;
    logic        rd_done_s;

    // Arbitration: grant selection, ready generation and request field mux.
    always_comb begin
        grant_s     = 1'b0;
        req_rwn_s   = r0_rwn;
        req_addr_s  = r0_addr;
        req_wdata_s = r0_wdata;
        if (r0_valid && r1_valid) begin
            grant_s = rr_r;
        end else if (r1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        // Accept requires at least one valid, so the granted side is valid.
        accept_s = (state_r == ST_IDLE) && (r0_valid || r1_valid);
        r0_ready = accept_s && !grant_s;
        r1_ready = accept_s && grant_s;
        if (grant_s) begin
            req_rwn_s   = r1_rwn;
            req_addr_s  = r1_addr;
            req_wdata_s = r1_wdata;
        end else begin
            req_rwn_s   = r0_rwn;
            req_addr_s  = r0_addr;
            req_wdata_s = r0_wdata;
        end
    end

    // Next-state and cycle-counter logic; the counter reloads on every state entry.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_SETUP;
                    cnt_next_s   = 8'd0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (lat_rwn_r) begin
                    state_next_s = ST_RDWAIT;
                    cnt_next_s   = READ_LOAD;
                end else begin
                    state_next_s = ST_STROBE;
                    cnt_next_s   = STROBE_LOAD;
                end
            end
            ST_STROBE, ST_RDWAIT: begin
                if (cnt_r == 8'd0) begin
                    state_next_s = ST_RECOVER;
                    cnt_next_s   = GAP_LOAD;
                end else begin
                    cnt_next_s = cnt_r - 8'd1;
                end
            end
            ST_RECOVER: begin
                if (cnt_r == 8'd0) begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = 8'd0;
                end else begin
                    cnt_next_s = cnt_r - 8'd1;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = 8'd0;
            end
        endcase
    end

    // Edge that ends the last RDWAIT cycle is where fm_din is sampled.
    assign rd_done_s = (state_r == ST_RDWAIT) && (cnt_r == 8'd0);

    // State, counter, round-robin pointer and latched access attributes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 8'd0;
            rr_r      <= 1'b0;
            lat_rwn_r <= 1'b0;
            lat_id_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            if (accept_s) begin
                rr_r      <= ~grant_s;
                lat_rwn_r <= req_rwn_s;
                lat_id_r  <= grant_s;
            end
        end
    end

    // Registered FM bus outputs, derived from the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            fm_addr <= 6'd0;
            fm_dout <= 8'd0;
            fm_oe   <= 1'b0;
            fm_rwn  <= 1'b1;
        end else begin
            fm_rwn <= (state_next_s != ST_STROBE);
            case (state_next_s)
                ST_SETUP:  fm_oe <= !req_rwn_s;
                ST_STROBE: fm_oe <= 1'b1;
                default:   fm_oe <= 1'b0;
            endcase
            if (accept_s) begin
                fm_addr <= req_addr_s;
                // Reads leave the write data register untouched.
                if (!req_rwn_s) begin
                    fm_dout <= req_wdata_s;
                end
            end
        end
    end

    // Read-data return to the originating requester only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r0_rdata  <= 8'd0;
            r0_rvalid <= 1'b0;
            r1_rdata  <= 8'd0;
            r1_rvalid <= 1'b0;
        end else begin
            r0_rvalid <= rd_done_s && !lat_id_r;
            r1_rvalid <= rd_done_s && lat_id_r;
            if (rd_done_s && !lat_id_r) begin
                r0_rdata <= fm_din;
            end
            if (rd_done_s && lat_id_r) begin
                r1_rdata <= fm_din;
            end
        end
    end

endmodule
